// File: rtl/game_flow_if.sv
// Bus bundle between the maze game-flow sequencer and its neighbours
// (keyboard decoder pulses, maps position, stopwatch, seven-segment path).
interface game_flow_if #(
  parameter int TIME_W = 14
);
  logic              tick;
  logic              start_pulse;
  logic              pause_pulse;
  logic [4:0]        row;
  logic [4:0]        column;
  logic [TIME_W-1:0] elapsed;
  logic              move_en;
  logic              sw_run;
  logic              sw_clear;
  logic              pos_reset;
  logic [2:0]        state;
  logic [3:0]        countdown;
  logic              game_state;
  logic [TIME_W-1:0] best_time;
  logic              new_record;

  modport master (
    output tick, start_pulse, pause_pulse, row, column, elapsed,
    input  move_en, sw_run, sw_clear, pos_reset, state, countdown,
           game_state, best_time, new_record
  );

  modport slave (
    input  tick, start_pulse, pause_pulse, row, column, elapsed,
    output move_en, sw_run, sw_clear, pos_reset, state, countdown,
           game_state, best_time, new_record
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Maze game-flow sequencer: IDLE/COUNTDOWN/PLAY/PAUSE/WON, trophy detection
// and best-time record keeping. All outputs are registered Moore outputs.
module game_flow_ctrl #(
  parameter int GOAL_ROW      = 23,
  parameter int GOAL_COL      = 31,
  parameter int CNT_SECS      = 3,
  parameter int TICKS_PER_SEC = 10,
  parameter int TIME_W        = 14
) (
  input  logic        clk,
  input  logic        rst,
  game_flow_if.slave  bus
);

  localparam int TCW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]     CD_START  = 4'(CNT_SECS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_WON       = 3'd4
  } state_t;

  state_t            state_r, next_state_s;
  logic [TCW-1:0]    tick_cnt_r, next_tick_cnt_s;
  logic [3:0]        countdown_r, next_countdown_s;
  logic [TIME_W-1:0] best_time_r, next_best_time_s;
  logic              new_record_r, next_new_record_s;
  logic              move_en_r, next_move_en_s;
  logic              sw_run_r, next_sw_run_s;
  logic              sw_clear_r, next_sw_clear_s;
  logic              pos_reset_r, next_pos_reset_s;
  logic              game_state_r, next_game_state_s;
  logic              at_goal_s;

  assign at_goal_s = (bus.row == 5'(GOAL_ROW)) && (bus.column == 5'(GOAL_COL));

  // Next-state, countdown, record and output decode; start outranks goal outranks pause
  always_comb begin
    next_state_s      = state_r;
    next_tick_cnt_s   = tick_cnt_r;
    next_countdown_s  = countdown_r;
    next_best_time_s  = best_time_r;
    next_new_record_s = new_record_r;
    next_sw_clear_s   = 1'b0;
    next_pos_reset_s  = 1'b0;

    if (bus.start_pulse) begin
      // Restart from anywhere; a coincident tick is deliberately dropped
      next_state_s      = ST_COUNTDOWN;
      next_countdown_s  = CD_START;
      next_tick_cnt_s   = '0;
      next_sw_clear_s   = 1'b1;
      next_pos_reset_s  = 1'b1;
      next_new_record_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_state_s = ST_IDLE;
        end
        ST_COUNTDOWN: begin
          if (bus.tick) begin
            if (tick_cnt_r == TICK_LAST) begin
              next_tick_cnt_s = '0;
              if (countdown_r == 4'd1) begin
                next_state_s     = ST_PLAY;
                next_countdown_s = 4'd0;
              end else begin
                next_countdown_s = countdown_r - 4'd1;
              end
            end else begin
              next_tick_cnt_s = tick_cnt_r + TCW'(1);
            end
          end else begin
            next_tick_cnt_s = tick_cnt_r;
          end
        end
        ST_PLAY: begin
          if (at_goal_s) begin
            next_state_s = ST_WON;
            // Equal time is not an improvement
            if (bus.elapsed < best_time_r) begin
              next_best_time_s  = bus.elapsed;
              next_new_record_s = 1'b1;
            end else begin
              next_new_record_s = 1'b0;
            end
          end else if (bus.pause_pulse) begin
            next_state_s = ST_PAUSE;
          end else begin
            next_state_s = ST_PLAY;
          end
        end
        ST_PAUSE: begin
          if (bus.pause_pulse) begin
            next_state_s = ST_PLAY;
          end else begin
            next_state_s = ST_PAUSE;
          end
        end
        ST_WON: begin
          next_state_s = ST_WON;
        end
        default: begin
          next_state_s     = ST_IDLE;
          next_countdown_s = 4'd0;
          next_tick_cnt_s  = '0;
        end
      endcase
    end

    next_move_en_s    = (next_state_s == ST_PLAY);
    next_sw_run_s     = (next_state_s == ST_PLAY);
    next_game_state_s = (next_state_s == ST_WON);
  end

  // State and registered-output update; reset also discards the best-time record
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      tick_cnt_r   <= '0;
      countdown_r  <= 4'd0;
      best_time_r  <= '1;
      new_record_r <= 1'b0;
      move_en_r    <= 1'b0;
      sw_run_r     <= 1'b0;
      sw_clear_r   <= 1'b0;
      pos_reset_r  <= 1'b0;
      game_state_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      tick_cnt_r   <= next_tick_cnt_s;
      countdown_r  <= next_countdown_s;
      best_time_r  <= next_best_time_s;
      new_record_r <= next_new_record_s;
      move_en_r    <= next_move_en_s;
      sw_run_r     <= next_sw_run_s;
      sw_clear_r   <= next_sw_clear_s;
      pos_reset_r  <= next_pos_reset_s;
      game_state_r <= next_game_state_s;
    end
  end

  assign bus.state      = state_r;
  assign bus.countdown  = countdown_r;
  assign bus.best_time  = best_time_r;
  assign bus.new_record = new_record_r;
  assign bus.move_en    = move_en_r;
  assign bus.sw_run     = sw_run_r;
  assign bus.sw_clear   = sw_clear_r;
  assign bus.pos_reset  = pos_reset_r;
  assign bus.game_state = game_state_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed stimulus pushes hand-computed
// expected output snapshots; a negedge monitor pops and compares them.
module tb_game_flow_ctrl;
  localparam int TW = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_flow_if #(.TIME_W(TW)) gif();

  game_flow_ctrl #(
    .GOAL_ROW(23), .GOAL_COL(31), .CNT_SECS(3), .TICKS_PER_SEC(10), .TIME_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(gif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [2:0]     st;
    logic [3:0]     cd;
    logic           mv, run, clr, pos, gs, nr;
    logic [TW-1:0]  best;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  logic [2:0]    e_st;
  logic [3:0]    e_cd;
  logic          e_clr, e_nr;
  logic [TW-1:0] e_best;

  // Moore relations: move/run only in PLAY, game_state only in WON, clear/pos together
  task automatic push(input string nm);
    exp_t e;
    e.name = nm;
    e.st   = e_st;
    e.cd   = e_cd;
    e.mv   = (e_st == 3'd2);
    e.run  = (e_st == 3'd2);
    e.clr  = e_clr;
    e.pos  = e_clr;
    e.gs   = (e_st == 3'd4);
    e.nr   = e_nr;
    e.best = e_best;
    sb_q.push_back(e);
  endtask

  task automatic expect_state(input logic [2:0] st, input logic [3:0] cd,
                              input logic clr, input logic nr);
    e_st = st; e_cd = cd; e_clr = clr; e_nr = nr;
  endtask

  task automatic cyc(input logic s, input logic p, input logic t);
    gif.start_pulse = s;
    gif.pause_pulse = p;
    gif.tick        = t;
    @(posedge clk);
    #1;
    gif.start_pulse = 1'b0;
    gif.pause_pulse = 1'b0;
    gif.tick        = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic goal(input logic on);
    gif.row    = on ? 5'd23 : 5'd0;
    gif.column = on ? 5'd31 : 5'd0;
  endtask

  // Monitor: compare every pending expectation against the live outputs
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (gif.state !== e.st || gif.countdown !== e.cd || gif.move_en !== e.mv ||
          gif.sw_run !== e.run || gif.sw_clear !== e.clr || gif.pos_reset !== e.pos ||
          gif.game_state !== e.gs || gif.new_record !== e.nr || gif.best_time !== e.best) begin
        errors++;
        $display("FAIL %s: got st=%0d cd=%0d mv=%b run=%b clr=%b pos=%b gs=%b nr=%b best=%0d, want st=%0d cd=%0d mv=%b run=%b clr=%b pos=%b gs=%b nr=%b best=%0d",
                 e.name, gif.state, gif.countdown, gif.move_en, gif.sw_run, gif.sw_clear,
                 gif.pos_reset, gif.game_state, gif.new_record, gif.best_time,
                 e.st, e.cd, e.mv, e.run, e.clr, e.pos, e.gs, e.nr, e.best);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gif.tick = 1'b0; gif.start_pulse = 1'b0; gif.pause_pulse = 1'b0;
    gif.row = 5'd0; gif.column = 5'd0; gif.elapsed = '0;
    e_best = 14'd16383;
    expect_state(3'd0, 4'd0, 1'b0, 1'b0);
    push("reset");
    #12 rst = 1'b1;

    cyc(1'b0, 1'b0, 1'b0);  push("idle_hold");
    cyc(1'b0, 1'b1, 1'b1);  push("idle_ignores_pause_tick");

    // Countdown: 3 through tick 9, 2 after 10, 1 after 20, PLAY after 30
    cyc(1'b1, 1'b0, 1'b0); expect_state(3'd1, 4'd3, 1'b1, 1'b0); push("start_cd");
    cyc(1'b0, 1'b0, 1'b0); expect_state(3'd1, 4'd3, 1'b0, 1'b0); push("clear_one_cycle");
    ticks(9);  push("cd_t9");
    ticks(1);  e_cd = 4'd2; push("cd_t10");
    ticks(10); e_cd = 4'd1; push("cd_t20");
    ticks(9);  push("cd_t29");
    ticks(1);  expect_state(3'd2, 4'd0, 1'b0, 1'b0); push("play");

    // Pause holds the stopwatch, ticks do nothing
    cyc(1'b0, 1'b1, 1'b0); e_st = 3'd3; push("pause");
    ticks(5); push("pause_ticks");
    cyc(1'b0, 1'b1, 1'b0); e_st = 3'd2; push("resume");

    // First finish sets the record
    goal(1'b1); gif.elapsed = 14'd250;
    cyc(1'b0, 1'b0, 1'b0); e_st = 3'd4; e_nr = 1'b1; e_best = 14'd250; push("won1");
    checks++;
    if (gif.best_time !== 14'd250 || gif.new_record !== 1'b1 || gif.game_state !== 1'b1) begin
      errors++;
      $display("FAIL won1_direct: best=%0d nr=%b gs=%b", gif.best_time, gif.new_record, gif.game_state);
    end
    cyc(1'b0, 1'b1, 1'b1); push("won_hold");
    goal(1'b0);
    cyc(1'b1, 1'b0, 1'b0); expect_state(3'd1, 4'd3, 1'b1, 1'b0); push("restart_from_won");
    ticks(30); expect_state(3'd2, 4'd0, 1'b0, 1'b0); push("play2");
    goal(1'b1); gif.elapsed = 14'd250;
    cyc(1'b0, 1'b0, 1'b0); e_st = 3'd4; push("won_equal");

    goal(1'b0);
    cyc(1'b1, 1'b0, 1'b0); ticks(30);
    goal(1'b1); gif.elapsed = 14'd180;
    cyc(1'b0, 1'b0, 1'b0); expect_state(3'd4, 4'd0, 1'b0, 1'b1); e_best = 14'd180;
    push("won_better");

    // Goal outranks pause; start outranks goal
    goal(1'b0);
    cyc(1'b1, 1'b0, 1'b0); ticks(30);
    goal(1'b1); gif.elapsed = 14'd200;
    cyc(1'b0, 1'b1, 1'b0); expect_state(3'd4, 4'd0, 1'b0, 1'b0); push("goal_over_pause");
    cyc(1'b1, 1'b0, 1'b0); expect_state(3'd1, 4'd3, 1'b1, 1'b0); push("start_over_goal");

    // Goal already present when PLAY begins is caught on the first PLAY cycle
    ticks(30); expect_state(3'd2, 4'd0, 1'b0, 1'b0); push("play_goal_held");
    gif.elapsed = 14'd100;
    cyc(1'b0, 1'b0, 1'b0); expect_state(3'd4, 4'd0, 1'b0, 1'b1); e_best = 14'd100;
    push("goal_first_play");

    // Restart with coincident tick at countdown=1: tick dropped, counter restarted
    goal(1'b0);
    cyc(1'b1, 1'b0, 1'b0); ticks(25); expect_state(3'd1, 4'd1, 1'b0, 1'b0); push("cd_one");
    cyc(1'b1, 1'b0, 1'b1); expect_state(3'd1, 4'd3, 1'b1, 1'b0); push("restart_tick");
    checks++;
    if (gif.countdown !== 4'd3 || gif.state !== 3'd1) begin
      errors++;
      $display("FAIL restart_tick_direct: st=%0d cd=%0d", gif.state, gif.countdown);
    end
    ticks(9); e_clr = 1'b0; push("restart_t9");
    ticks(1); e_cd = 4'd2; push("restart_t10");
    cyc(1'b0, 1'b1, 1'b0); push("cd_pause_ignored");
    ticks(20); expect_state(3'd2, 4'd0, 1'b0, 1'b0); push("play3");

    // Asynchronous reset mid-PLAY, observed before the next clock edge
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if (gif.state !== 3'd0 || gif.move_en !== 1'b0 || gif.sw_run !== 1'b0 ||
        gif.best_time !== 14'd16383 || gif.countdown !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_direct: st=%0d mv=%b run=%b best=%0d cd=%0d",
               gif.state, gif.move_en, gif.sw_run, gif.best_time, gif.countdown);
    end
    expect_state(3'd0, 4'd0, 1'b0, 1'b0); e_best = 14'd16383; push("async_reset");
    @(negedge clk); #1;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0); push("post_reset_idle");

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Game-flow sequencer for the maze game. It sits between the keyboard/decoder pulses, the maps position logic, and the stopwatch. It gates movement and stopwatch counting through IDLE / COUNTDOWN / PLAY / PAUSE / WON, and detects arrival at the trophy cell. It also keeps a best-time record for the seven-segment display path.

Parameters:
GOAL_ROW, 23, trophy cell row index
GOAL_COL, 31, trophy cell column index
CNT_SECS, 3, countdown length in seconds (1..9)
TICKS_PER_SEC, 10, tick pulses per countdown second
TIME_W, 14, width of elapsed/best time in tenths of a second

Ports:
clk  in  1  system clock; all logic in this domain
rst  in  1  reset, asynchronous, active-low (asserted when 0)
tick  in  1  10 Hz enable, one clk cycle wide, synchronous to clk
start_pulse  in  1  one-cycle start/restart request (decoded key)
pause_pulse  in  1  one-cycle pause toggle request
row  in  5  current character row from maps
column  in  5  current character column from maps
elapsed  in  TIME_W  stopwatch elapsed time, tenths of a second
move_en  out  1  maps may accept movement keys
sw_run  out  1  stopwatch counting enable
sw_clear  out  1  one-cycle stopwatch clear
pos_reset  out  1  one-cycle request for maps to return character to start cell
state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, WON=4
countdown  out  4  remaining countdown seconds, for display; 0 outside COUNTDOWN
game_state  out  1  1 while in WON
best_time  out  TIME_W  best finishing time; all-ones = no record
new_record  out  1  last finish improved best_time; held while in WON

Behaviour:
- All outputs are registered (Moore). State changes take effect one clk after the sampled input.
- Reset (rst=0, asynchronous):
  - state=IDLE; move_en, sw_run, sw_clear, pos_reset, game_state, new_record = 0; countdown=0.
  - best_time = all ones; internal tick counter = 0.
  - Reset mid-game abandons the run and also clears the record.
- Input priority in any single cycle: start_pulse > goal detect > pause_pulse. tick is independent of the pulses except as stated below.
- Any state, start_pulse=1:
  - Next state COUNTDOWN; countdown=CNT_SECS; tick counter=0.
  - sw_clear=1 and pos_reset=1 for exactly one cycle.
  - game_state and new_record go to 0.
  - A start_pulse during COUNTDOWN restarts the countdown.
- IDLE: move_en=0, sw_run=0. Waits for start_pulse.
- COUNTDOWN: move_en=0, sw_run=0; pause_pulse ignored.
  - On each tick the tick counter increments.
  - At a tick with counter==TICKS_PER_SEC-1: counter wraps to 0 and countdown decrements.
  - If countdown was 1 at that tick: go to PLAY, countdown=0.
  - Total duration = CNT_SECS*TICKS_PER_SEC ticks (30 by default).
- PLAY: move_en=1, sw_run=1.
  - row==GOAL_ROW and column==GOAL_COL: go to WON. move_en and sw_run drop to 0 in the same cycle game_state rises.
  - Otherwise pause_pulse: go to PAUSE.
- PAUSE: move_en=0, sw_run=0. pause_pulse returns to PLAY; tick has no effect.
- WON: game_state=1, move_en=0, sw_run=0.
  - In the PLAY->WON transition cycle, the value of elapsed is compared unsigned with best_time.
  - If elapsed < best_time: best_time<=elapsed and new_record<=1; otherwise new_record<=0.
  - An equal time is not a new record. Only start_pulse leaves WON.
- Goal position present while entering PLAY from COUNTDOWN or PAUSE is detected on the first PLAY cycle.
- tick coincident with start_pulse in COUNTDOWN: the restart wins; the tick is not counted.

Test Plan:
1. rst=0 pulse mid-PLAY -> state=0, move_en=0, sw_run=0, best_time=16383, countdown=0, asynchronously before the next clk edge.
2. start_pulse in IDLE, then 30 ticks:
   - Required: sw_clear and pos_reset high exactly 1 cycle.
   - countdown reads 3 through tick 9, 2 after tick 10, 1 after tick 20.
   - state=PLAY, move_en=1, sw_run=1 after tick 30.
3. In PLAY, pause_pulse -> state=3, sw_run=0. 5 ticks later the stopwatch is held. pause_pulse again -> state=2, sw_run=1.
4. In PLAY, set row=23, column=31 with elapsed=250:
   - state=4 and game_state=1 next cycle; best_time=250, new_record=1.
   - Second run finishing at elapsed=250 -> best_time stays 250, new_record=0.
   - Third run at 180 -> best_time=180, new_record=1.
5. Same cycle goal reached and pause_pulse=1 -> WON. Same cycle start_pulse=1 and goal -> COUNTDOWN, countdown=3, game_state=0.
6. start_pulse at countdown=1 with tick asserted the same cycle -> countdown=3, tick counter restarted, state stays COUNTDOWN.
